addsub_arbiter: RTL

Round-robin arbiter and sequencer that shares one N-bit adder/subtractor among R requesters. It latches the winning requester's operands and operation select, and drives them through the shared add/sub datapath. The result is registered with carry and signed-overflow flags and returned to the winner with a tagged valid pulse. It sits between the client blocks (ALU micro-sequencers, address generators) and the single arithmetic unit, so the unit is never instantiated per client.

---
 rtl/addsub_arbiter_if.sv | 31 +++
 rtl/addsub_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter_if.sv
// Request/operand/result bundle between clients and addsub_arbiter.
// master: client side (drives req/operands), slave: arbiter side.
interface addsub_arbiter_if #(
  parameter int N = 4,
  parameter int R = 4
) ();
  localparam int W = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]   req;
  logic [R*N-1:0] x_bus;
  logic [R*N-1:0] y_bus;
  logic [R-1:0]   add_n_bus;
  logic [R-1:0]   lock;
  logic [R-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   z;
  logic           c_out;
  logic           v;
  logic           valid;
  logic [W-1:0]   owner;

  modport master (
    output req, x_bus, y_bus, add_n_bus, lock,
    input  gnt, busy, z, c_out, v, valid, owner
  );

  modport slave (
    input  req, x_bus, y_bus, add_n_bus, lock,
    output gnt, busy, z, c_out, v, valid, owner
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one N-bit add/sub among R requesters.
// Ports: clk, rst_n (async low), bus (slave: req/operands in; gnt,
// busy, z, c_out, v, valid, owner out). Optional ADDSUB_ARB_LOCK_EN
// lets the current owner hold the unit back-to-back via lock.
module addsub_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input logic        clk,
  input logic        rst_n,
  addsub_arbiter_if.slave bus
);
  localparam int W = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sub;
  } opnd_t;

  state_t       state_q;
  state_t       state_d;
  opnd_t        op_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] cur_q;
  logic [W-1:0] nxt_ptr;
  logic [W-1:0] win;
  logic         lock_q;
  logic         lock_hit;
  logic         grant;

  logic [N-1:0] z_q;
  logic         c_q;
  logic         v_q;
  logic [W-1:0] own_q;

  logic [N-1:0] y_eff;
  logic [N:0]   full;
  logic [N-1:0] low;
  logic         v_c;

  logic [R-1:0] gnt_c;
  logic         busy_c;
  logic         valid_c;

  function automatic logic [W-1:0] rr_pick(
    input logic [R-1:0] r,
    input logic [W-1:0] p
  );
    logic [W-1:0] w;
    int idx;
    w = '0;
    // descending scan so the closest requester after p wins
    for (int k = R - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % R;
      if (r[idx]) w = W'(idx);
    end
    return w;
  endfunction

  always_comb begin
    lock_hit = 1'b0;
`ifdef ADDSUB_ARB_LOCK_EN
    lock_hit = (state_q == DONE) &&
               bus.lock[cur_q] && bus.req[cur_q];
`endif
    win   = lock_hit ? cur_q : rr_pick(bus.req, ptr_q);
    grant = (state_q != EXEC) && (|bus.req);
  end

`ifndef ADDSUB_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.lock;
`endif

  assign nxt_ptr = (cur_q == W'(R - 1)) ? '0 : cur_q + 1'b1;

  // shared datapath: subtract is X + ~Y + 1
  always_comb begin
    y_eff = op_q.sub ? ~op_q.y : op_q.y;
    full  = {1'b0, op_q.x} + {1'b0, y_eff} +
            {{N{1'b0}}, op_q.sub};
    // low[N-1] is the carry into the MSB stage
    low   = {1'b0, op_q.x[N-2:0]} +
            {1'b0, y_eff[N-2:0]} +
            {{(N-1){1'b0}}, op_q.sub};
    v_c   = low[N-1] ^ full[N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = grant ? EXEC : IDLE;
      EXEC:    state_d = DONE;
      DONE:    state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c   = '0;
    if (state_q == EXEC) gnt_c[cur_q] = 1'b1;
    busy_c  = (state_q == EXEC) ||
              ((state_q == DONE) && grant);
    valid_c = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      cur_q  <= '0;
      lock_q <= 1'b0;
      ptr_q  <= '0;
      z_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      own_q  <= '0;
    end else begin
      if (grant) begin
        op_q.x   <= bus.x_bus[int'(win)*N +: N];
        op_q.y   <= bus.y_bus[int'(win)*N +: N];
        op_q.sub <= bus.add_n_bus[win];
        cur_q    <= win;
        lock_q   <= lock_hit;
      end
      if (state_q == EXEC) begin
        z_q   <= full[N-1:0];
        c_q   <= full[N];
        v_q   <= v_c;
        own_q <= cur_q;
        // a locked re-grant keeps the pointer where it was
        if (!lock_q) ptr_q <= nxt_ptr;
      end
    end
  end

  assign bus.gnt   = gnt_c;
  assign bus.busy  = busy_c;
  assign bus.valid = valid_c;
  assign bus.z     = z_q;
  assign bus.c_out = c_q;
  assign bus.v     = v_q;
  assign bus.owner = own_q;
endmodule
